// File: rtl/retire_rat.sv
// Retirement RAT: holds the committed arch->phys map, returns displaced physical
// registers to the free list, and streams the map to the front-end RAT on a mispredict.
module retire_rat #(
  parameter int PREG_W    = 6,
  parameter int ARCH_REGS = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              commit_valid,
  input  logic              commit_regwrite,
  input  logic [4:0]        commit_arch_rd,
  input  logic [PREG_W-1:0] commit_phys_rd,
  input  logic              commit_mispredict,
  output logic              commit_ready,
  output logic              free_enqueue,
  output logic [PREG_W-1:0] free_wdata,
  output logic              flush,
  output logic              restore_valid,
  output logic [4:0]        restore_arch_idx,
  output logic [PREG_W-1:0] restore_phys,
  output logic              restore_done
);

  localparam logic [4:0] LAST_IDX = 5'(ARCH_REGS - 1);

  typedef enum logic {IDLE, RESTORE} state_e;

  state_e            state_q, state_d;
  logic [4:0]        rcnt_q, rcnt_d;
  logic [PREG_W-1:0] rrat_q [ARCH_REGS];

  logic              ready_q, ready_d;
  logic              enq_q, enq_d;
  logic [PREG_W-1:0] wdata_q, wdata_d;
  logic              flush_q, flush_d;
  logic              rvld_q, rvld_d;
  logic [4:0]        ridx_q, ridx_d;
  logic [PREG_W-1:0] rphys_q, rphys_d;
  logic              rdone_q, rdone_d;

  logic accept, upd, mispred, last_beat;

  // Commits are only honoured while ready is high; anything else is dropped.
  assign accept    = commit_valid && ready_q && (state_q == IDLE);
  assign upd       = accept && commit_regwrite && (commit_arch_rd != 5'd0);
  assign mispred   = accept && commit_mispredict;
  assign last_beat = (state_q == RESTORE) && (rcnt_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    unique case (state_q)
      IDLE: begin
        if (mispred) begin
          state_d = RESTORE;
          rcnt_d  = '0;
        end
      end
      RESTORE: begin
        rcnt_d = last_beat ? 5'd0 : rcnt_q + 5'd1;
        if (last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    enq_d   = upd;
    wdata_d = upd ? rrat_q[commit_arch_rd] : wdata_q;
    flush_d = mispred;
    rvld_d  = (state_q == RESTORE);
    ridx_d  = (state_q == RESTORE) ? rcnt_q : ridx_q;
    rphys_d = (state_q == RESTORE) ? rrat_q[rcnt_q] : rphys_q;
    // done and ready follow the last beat by one cycle, so the last beat is on the wire first
    rdone_d = rvld_q && (ridx_q == LAST_IDX);
    ready_d = ready_q;
    if (mispred) ready_d = 1'b0;
    if (rdone_d) ready_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      ready_q <= 1'b1;
      enq_q   <= 1'b0;
      wdata_q <= '0;
      flush_q <= 1'b0;
      rvld_q  <= 1'b0;
      ridx_q  <= '0;
      rphys_q <= '0;
      rdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      ready_q <= ready_d;
      enq_q   <= enq_d;
      wdata_q <= wdata_d;
      flush_q <= flush_d;
      rvld_q  <= rvld_d;
      ridx_q  <= ridx_d;
      rphys_q <= rphys_d;
      rdone_q <= rdone_d;
    end
  end

  // Table write lands at the edge, so a same-rd commit next cycle reads the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) rrat_q[i] <= PREG_W'(i);
    end else if (upd) begin
      rrat_q[commit_arch_rd] <= commit_phys_rd;
    end
  end

  assign commit_ready     = ready_q;
  assign free_enqueue     = enq_q;
  assign free_wdata       = wdata_q;
  assign flush            = flush_q;
  assign restore_valid    = rvld_q;
  assign restore_arch_idx = ridx_q;
  assign restore_phys     = rphys_q;
  assign restore_done     = rdone_q;

endmodule

// File: tb/tb_retire_rat.sv
// Scoreboard bench for retire_rat: stimulus queues cycle-stamped expectations,
// a negedge monitor pops and compares whenever the DUT strobes an output.
module tb_retire_rat;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          commit_valid = 1'b0, commit_regwrite = 1'b0, commit_mispredict = 1'b0;
  logic [4:0]    commit_arch_rd = '0;
  logic [PW-1:0] commit_phys_rd = '0;
  logic          commit_ready, free_enqueue, flush, restore_valid, restore_done;
  logic [PW-1:0] free_wdata, restore_phys;
  logic [4:0]    restore_arch_idx;

  retire_rat #(.PREG_W(PW), .ARCH_REGS(32)) dut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_regwrite(commit_regwrite),
    .commit_arch_rd(commit_arch_rd), .commit_phys_rd(commit_phys_rd),
    .commit_mispredict(commit_mispredict), .commit_ready(commit_ready),
    .free_enqueue(free_enqueue), .free_wdata(free_wdata), .flush(flush),
    .restore_valid(restore_valid), .restore_arch_idx(restore_arch_idx),
    .restore_phys(restore_phys), .restore_done(restore_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0, nerr = 0;
  bit mon_en = 1'b0;

  typedef struct { int cyc; logic [PW-1:0] val; } fexp_t;
  typedef struct { int cyc; logic [4:0] idx; logic [PW-1:0] phys; } rexp_t;
  fexp_t free_q[$];
  rexp_t rest_q[$];
  int    flush_q[$];
  int    done_q[$];
  logic [PW-1:0] model [32];

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string nm, input int val);
    nvec++;
    nerr++;
    $display("FAIL %s: got strobe (data %0d) at cycle %0d, want none", nm, val, cyc);
  endtask

  // Monitor
  always @(negedge clk) begin : mon
    fexp_t fe;
    rexp_t re;
    int    c;
    if (mon_en) begin
      if (free_enqueue) begin
        if (free_q.size() == 0) unexpected("free_enqueue", int'(free_wdata));
        else begin
          fe = free_q.pop_front();
          chk("free_cycle", cyc, fe.cyc);
          chk("free_wdata", int'(free_wdata), int'(fe.val));
        end
      end
      if (flush) begin
        if (flush_q.size() == 0) unexpected("flush", 1);
        else begin c = flush_q.pop_front(); chk("flush_cycle", cyc, c); end
      end
      if (restore_valid) begin
        if (rest_q.size() == 0) unexpected("restore_valid", int'(restore_arch_idx));
        else begin
          re = rest_q.pop_front();
          chk("restore_cycle", cyc, re.cyc);
          chk("restore_idx", int'(restore_arch_idx), int'(re.idx));
          chk("restore_phys", int'(restore_phys), int'(re.phys));
        end
      end
      if (restore_done) begin
        if (done_q.size() == 0) unexpected("restore_done", 1);
        else begin c = done_q.pop_front(); chk("done_cycle", cyc, c); end
      end
    end
  end

  task automatic model_reset();
    for (int i = 0; i < 32; i++) model[i] = PW'(i);
  endtask

  // One accepted commit; exp_free is the hand-computed displaced register.
  task automatic cmt(input logic [4:0] rd, input logic [PW-1:0] ph, input bit rw, input bit mp,
                     input bit exp_en, input logic [PW-1:0] exp_free, input int nbeats);
    @(posedge clk); #1;
    commit_valid = 1'b1; commit_regwrite = rw; commit_mispredict = mp;
    commit_arch_rd = rd; commit_phys_rd = ph;
    if (exp_en) free_q.push_back('{cyc + 1, exp_free});
    if (rw && rd != 5'd0) model[rd] = ph;
    if (mp) begin
      flush_q.push_back(cyc + 1);
      for (int i = 0; i < nbeats; i++) rest_q.push_back('{cyc + 2 + i, 5'(i), model[i]});
      if (nbeats == 32) done_q.push_back(cyc + 34);
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
    commit_valid = 1'b0; commit_regwrite = 1'b0; commit_mispredict = 1'b0;
    commit_arch_rd = '0; commit_phys_rd = '0;
  endtask

  int k;

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_commit_ready", int'(commit_ready), 1);
    chk("rst_free_enqueue", int'(free_enqueue), 0);
    chk("rst_free_wdata", int'(free_wdata), 0);
    chk("rst_flush", int'(flush), 0);
    chk("rst_restore_valid", int'(restore_valid), 0);
    chk("rst_restore_idx", int'(restore_arch_idx), 0);
    chk("rst_restore_phys", int'(restore_phys), 0);
    chk("rst_restore_done", int'(restore_done), 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Basic free of the identity mapping, then back-to-back same-rd commits
    cmt(5'd5, 6'd40, 1, 0, 1, 6'd5, 32);
    cmt(5'd5, 6'd41, 1, 0, 1, 6'd40, 32);
    cmt(5'd5, 6'd42, 1, 0, 1, 6'd41, 32);
    // x0 write and non-writing commit free nothing
    cmt(5'd0, 6'd33, 1, 0, 0, 6'd0, 32);
    cmt(5'd7, 6'd34, 0, 0, 0, 6'd0, 32);
    idle();

    // Mispredict with link write: full 32-beat restore
    cmt(5'd3, 6'd50, 1, 1, 1, 6'd3, 32);
    k = cyc;
    idle();
    chk("ready_in_flush", int'(commit_ready), 0);
    repeat (4) idle();
    // Protocol-violating commit during restore must be dropped
    @(posedge clk); #1;
    commit_valid = 1'b1; commit_regwrite = 1'b1; commit_mispredict = 1'b1;
    commit_arch_rd = 5'd6; commit_phys_rd = 6'd55;
    while (cyc < k + 33) idle();
    chk("ready_last_beat", int'(commit_ready), 0);
    // Accepted exactly 34 cycles after the mispredict commit
    cmt(5'd3, 6'd51, 1, 1, 1, 6'd50, 11);
    chk("ready_at_34", int'(commit_ready), 1);
    k = cyc;

    // Reset during beat 10 aborts the stream
    while (cyc < k + 11) idle();
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_restore_valid", int'(restore_valid), 0);
    chk("abort_restore_done", int'(restore_done), 0);
    chk("abort_commit_ready", int'(commit_ready), 1);

    // Fresh restore must stream the reset (identity) map
    cmt(5'd0, 6'd0, 0, 1, 0, 6'd0, 32);
    k = cyc;
    while (cyc < k + 33) idle();
    cmt(5'd8, 6'd60, 1, 0, 1, 6'd8, 32);
    repeat (4) idle();

    chk("free_q_left", free_q.size(), 0);
    chk("restore_q_left", rest_q.size(), 0);
    chk("flush_q_left", flush_q.size(), 0);
    chk("done_q_left", done_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
